// File: rtl/seq_div_32.sv
// seq_div_32: sequential 32-bit signed divider.
// Non-restoring, one quotient bit per clock. The result is {remainder, quotient},
// and the remainder takes the sign of the dividend.
// Latency is fixed at 34 clocks from accepting start to done.
// Optional feature: define SEQ_DIV_DBZ_FLAG_EN to add the dbz (divide-by-zero) output.
module seq_div_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
`ifdef SEQ_DIV_DBZ_FLAG_EN
    output logic        dbz,
`endif
    output logic [63:0] z
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;       // iteration counter, 0..31
    logic        fix_q, fix_d;       // FIXUP sub-step: 0 = correct remainder, 1 = apply signs
    logic [32:0] p_q, p_d;           // signed partial remainder
    logic [31:0] q_q, q_d;           // dividend magnitude shifting out, quotient shifting in
    logic [31:0] b_q, b_d;           // divisor magnitude
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        bz_q, bz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] z_q, z_d;
`ifdef SEQ_DIV_DBZ_FLAG_EN
    logic        dbz_q, dbz_d;
`endif

    logic [32:0] shifted;
    logic [32:0] p_next;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Next-state and datapath computation for every register.
    always_comb begin
        // NOTE: every signal gets a hold default before the case statement.
        // This means a path that does not assign a signal never infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        fix_d   = fix_q;
        p_d     = p_q;
        q_d     = q_q;
        b_d     = b_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        bz_d    = bz_q;
        busy_d  = busy_q;
        done_d  = done_q;
        z_d     = z_q;
`ifdef SEQ_DIV_DBZ_FLAG_EN
        dbz_d   = dbz_q;
`endif
        shifted = {p_q[31:0], q_q[31]};
        p_next  = p_q[32] ? shifted + {1'b0, b_q} : shifted - {1'b0, b_q};
        q_fix   = q_neg_q ? (~q_q + 32'd1) : q_q;
        r_fix   = r_neg_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    fix_d   = 1'b0;
                    p_d     = 33'd0;
                    q_d     = a[31] ? (~a + 32'd1) : a;
                    b_d     = b[31] ? (~b + 32'd1) : b;
                    q_neg_d = a[31] ^ b[31];
                    r_neg_d = a[31];
                    bz_d    = (b == 32'd0);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                p_d   = p_next;
                q_d   = {q_q[30:0], ~p_next[32]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (!fix_q) begin
                    if (p_q[32]) begin
                        p_d = p_q + {1'b0, b_q};
                    end
                    fix_d = 1'b1;
                end else begin
                    // Divide by zero: the remainder already equals |a| and is re-signed to a.
                    // The quotient is forced to all ones.
                    z_d     = {r_fix, bz_q ? 32'hFFFF_FFFF : q_fix};
                    fix_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SEQ_DIV_DBZ_FLAG_EN
                    dbz_d   = bz_q;
`endif
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
`ifdef SEQ_DIV_DBZ_FLAG_EN
                dbz_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. An asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop is reset, including the datapath registers.
        // After reset, no stale operand or partial result can leak into z.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            fix_q   <= 1'b0;
            p_q     <= 33'd0;
            q_q     <= 32'd0;
            b_q     <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            bz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 64'd0;
`ifdef SEQ_DIV_DBZ_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all flops update together from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fix_q   <= fix_d;
            p_q     <= p_d;
            q_q     <= q_d;
            b_q     <= b_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            bz_q    <= bz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
`ifdef SEQ_DIV_DBZ_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
`ifdef SEQ_DIV_DBZ_FLAG_EN
    assign dbz  = dbz_q;
`endif

endmodule

// File: doc/seq_div_32.md
SEQ_DIV_32 -- requirements
Module: seq_div_32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL reset asynchronously on rst_n low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  32  signed dividend, captured on accepted start.
REQ-006 b  input  32  signed divisor, captured on accepted start.
REQ-007 busy  output  1  high from the edge after start acceptance until the edge that asserts done.
REQ-008 done  output  1  single-cycle pulse; z is valid when done is high.
REQ-009 z  output  64  result, {remainder[31:0], quotient[31:0]}, so that z[63:32] is HI and z[31:0] is LO.
REQ-010 dbz  output  1  divide-by-zero flag, valid with done; present only when the macro in REQ-025 is defined.

Function
REQ-011 States SHALL be IDLE, RUN, FIXUP and DONE.
- IDLE->RUN on start=1.
- RUN->FIXUP after exactly 32 iterations.
- FIXUP->DONE.
- DONE->IDLE unconditionally.
REQ-012 On acceptance, the block SHALL latch the magnitudes |a| and |b|, the quotient sign (a[31]^b[31]), the remainder sign (a[31]) and b==0.
REQ-013 RUN SHALL perform one unsigned non-restoring iteration per clock on a 33-bit partial remainder; an iteration counter SHALL count 0..31.
REQ-014 FIXUP SHALL:
- add |b| to a negative partial remainder;
- apply the quotient sign and remainder sign by two's complement;
- write the result to z.
REQ-015 done SHALL be high for exactly the one cycle in DONE; latency from the start-sampling edge to the done-asserting edge SHALL be 34 clocks, independent of operand values.
REQ-016 Rounding SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign, or the remainder SHALL be zero; a = q*b + r SHALL hold for b != 0.
REQ-017 Overflow: a=0x80000000, b=0xFFFFFFFF SHALL yield q=0x80000000, r=0, with no flag.
REQ-018 b==0 SHALL yield q=0xFFFFFFFF, r=a, with the same 34-clock latency.
REQ-019 start while busy, or in DONE, SHALL be ignored; a and b changes after acceptance SHALL not affect the result.
REQ-020 z SHALL hold its last value outside FIXUP; it SHALL change only at the FIXUP->DONE edge.
REQ-021 start may be asserted in the cycle after done; it SHALL then be accepted from IDLE with no lost cycle beyond the IDLE state.

Reset
REQ-022 On rst_n low:
- state=IDLE, counter=0;
- busy=0, done=0, z=0, dbz=0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; z SHALL read 0 after reset.
REQ-024 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-025 Macro SEQ_DIV_DBZ_FLAG_EN:
- Defined: port dbz SHALL exist and be high with done when the latched b==0, otherwise low.
- Undefined: port dbz and its register SHALL be absent.
- In both cases, z behaviour SHALL be identical.

Verification
REQ-026 a=100, b=7, start pulse -> done 34 clocks later, z=0x00000002_0000000E, dbz=0.
REQ-027 a=-100 (0xFFFFFF9C), b=7 -> z=0xFFFFFFFE_FFFFFFF2; a=100, b=-7 -> z=0x00000002_FFFFFFF2.
REQ-028 a=0x80000000, b=0xFFFFFFFF -> z=0x00000000_80000000; a=5, b=0 -> z=0x00000005_FFFFFFFF, dbz=1 when the macro is defined.
REQ-029 Start accepted, then start re-pulsed with new operands at clock 10 -> original result only, a single done pulse, busy never drops early.
REQ-030 rst_n pulsed low at clock 15 of RUN -> busy=0, z=0, no done; a new start with a=9, b=3 -> z=0x00000000_00000003 after 34 clocks.
